// File: rtl/pdp_fp16_sum_seq_if.sv
// ============================================================================
// Module   : pdp_fp16_sum_seq_if
// Brief    : Upstream, adder and downstream handshakes of the PDP sum-pooling sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pdp_fp16_sum_seq_if #(
  parameter int DW = 68
);
  logic          in_pvld;
  logic          in_prdy;
  logic [DW-1:0] in_pd;
  logic          add_in_pvld;
  logic          add_in_prdy;
  logic [DW-1:0] add_in_a;
  logic [DW-1:0] add_in_b;
  logic          add_out_pvld;
  logic          add_out_prdy;
  logic [DW-1:0] add_out_dp;
  logic          out_pvld;
  logic          out_prdy;
  logic [DW-1:0] out_pd;

  // master is the sequencer; slave is its upstream, adder and downstream
  modport master (
    input  in_pvld, in_pd, add_in_prdy, add_out_pvld, add_out_dp, out_prdy,
    output in_prdy, add_in_pvld, add_in_a, add_in_b, add_out_prdy, out_pvld, out_pd
  );

  modport slave (
    output in_pvld, in_pd, add_in_prdy, add_out_pvld, add_out_dp, out_prdy,
    input  in_prdy, add_in_pvld, add_in_a, add_in_b, add_out_prdy, out_pvld, out_pd
  );
endinterface

`default_nettype wire

// File: rtl/pdp_fp16_sum_seq.sv
// ============================================================================
// Module   : pdp_fp16_sum_seq
// Brief    : Sum-pooling sequencer; folds an N-element window through an external 4-lane fp17 adder
// Revision : 1.0
// ============================================================================
`default_nettype none

module pdp_fp16_sum_seq #(
  parameter int DW   = 68,
  parameter int CNTW = 4
) (
  input  wire logic            nvdla_core_clk,
  input  wire logic            nvdla_core_rstn,
  input  wire logic [CNTW-1:0] cfg_win_size,
  pdp_fp16_sum_seq_if.master   bus,
  output logic                 busy,
  output logic                 err_unexp
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [CNTW:0] c_one = 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_acc;
  logic [CNTW:0] r_cnt;
  logic [CNTW:0] r_win;
  logic          r_err;
  logic [CNTW:0] w_cnt_inc;
  logic [CNTW:0] w_win_new;

  // one bit wider than the config so a full 2^CNTW window never wraps
  assign w_win_new = {1'b0, cfg_win_size} + c_one;
  assign w_cnt_inc = r_cnt + c_one;

  assign bus.add_in_a = r_acc;
  assign bus.add_in_b = bus.in_pd;
  assign bus.out_pd   = r_acc;
  assign busy         = (r_state != ST_IDLE);
  assign err_unexp    = r_err;

  always_comb begin
    w_state_nxt      = r_state;
    bus.in_prdy      = 1'b0;
    bus.add_in_pvld  = 1'b0;
    bus.add_out_prdy = 1'b0;
    bus.out_pvld     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.in_prdy = 1'b1;
        if (bus.in_pvld) begin
          w_state_nxt = (cfg_win_size == '0) ? ST_OUT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // the element is only taken when the adder takes the operand pair
        bus.add_in_pvld = bus.in_pvld;
        bus.in_prdy     = bus.add_in_prdy;
        if (bus.in_pvld && bus.add_in_prdy) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        bus.add_out_prdy = 1'b1;
        if (bus.add_out_pvld) begin
          w_state_nxt = (w_cnt_inc == r_win) ? ST_OUT : ST_ISSUE;
        end
      end
      ST_OUT: begin
        bus.out_pvld = 1'b1;
        if (bus.out_prdy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_win <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.in_pvld) begin
        r_acc <= bus.in_pd;
        r_cnt <= c_one;
        r_win <= w_win_new;
      end
      if (r_state == ST_WAIT && bus.add_out_pvld) begin
        r_acc <= bus.add_out_dp;
        r_cnt <= w_cnt_inc;
      end
      // a result with no outstanding add means the adder lost sync with us
      if (bus.add_out_pvld && r_state != ST_WAIT) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
